// File: rtl/dfp_bcd_isqrt_iter.sv
// Digit-recurrence BCD integer square root: o = floor(sqrt(a * 10^(3N))), one root digit per SHIFT + TRY pass.
// Optional macro BCD_ISQRT_EARLY_EXIT_EN ends each digit on the first failed trial subtraction.
module dfp_bcd_isqrt_iter #(
  parameter int N = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           ld,
  input  logic [4*N-1:0] a,
  output logic [8*N-1:0] o,
  output logic           done,
  output logic [1:0]     o_state
);

  localparam int AW = 4 * N;
  localparam int QW = 8 * N;
  localparam int RD = 2 * N + 4;
  localparam int RW = 4 * RD;
  localparam int PW = $clog2(2 * N);
  localparam logic [PW-1:0] LAST_PAIR = PW'(2 * N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_TRY   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ld is a one-cycle start strobe (taken only when ce=1, in any state);
  // done is a level that stays high until the next accepted ld or rst.
  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_a;
  logic [QW-1:0]   r_q;
  logic [RW-1:0]   r_r;
  logic [RW-1:0]   r_t;
  logic [3:0]      r_d;
  logic [3:0]      r_try;
  logic [PW-1:0]   r_pair;
  logic [QW-1:0]   r_o;
  logic            r_done;

  logic            w_ge;
  logic [RW-1:0]   w_sub;
  logic [RW-1:0]   w_t_inc;
  logic [RW-1:0]   w_t_init;
  logic [RW-1:0]   w_q10;
  logic [3:0]      w_d_next;
  logic [QW-1:0]   w_q_next;
  logic [7:0]      w_pair;
  logic            w_try_last;

  function automatic logic [RW-1:0] bcd_add(input logic [RW-1:0] x, input logic [RW-1:0] y,
                                            input logic cin);
    logic [RW-1:0] sum;
    logic          c;
    logic [4:0]    s;
    sum = '0;
    c   = cin;
    for (int i = 0; i < RD; i++) begin
      s = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      sum[4*i +: 4] = s[3:0];
    end
    return sum;
  endfunction

  function automatic logic [RW-1:0] bcd_nines(input logic [RW-1:0] x);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < RD; i++) r[4*i +: 4] = 4'd9 - x[4*i +: 4];
    return r;
  endfunction

  // Carry out of x + nines(y) + 1: set exactly when x >= y.
  function automatic logic bcd_geq(input logic [RW-1:0] x, input logic [RW-1:0] y);
    logic       c;
    logic [4:0] s;
    c = 1'b1;
    for (int i = 0; i < RD; i++) begin
      s = 5'(x[4*i +: 4]) + 5'(4'd9 - y[4*i +: 4]) + 5'(c);
      c = (s > 5'd9);
    end
    return c;
  endfunction

  assign w_ge     = bcd_geq(r_r, r_t);
  assign w_sub    = bcd_add(r_r, bcd_nines(r_t), 1'b1);
  assign w_t_inc  = bcd_add(r_t, RW'(2), 1'b0);
  // 20Q+1 as 10Q + 10Q with carry-in 1 (low digit of 10Q is zero).
  assign w_q10    = RW'({r_q, 4'd0});
  assign w_t_init = bcd_add(w_q10, w_q10, 1'b1);
  assign w_d_next = r_d + {3'd0, w_ge};
  assign w_q_next = {r_q[QW-5:0], w_d_next};
  assign w_pair   = r_a[AW-1 -: 8];

`ifdef BCD_ISQRT_EARLY_EXIT_EN
  assign w_try_last = !w_ge || (r_try == 4'd8);
`else
  assign w_try_last = (r_try == 4'd8);
`endif

  always_ff @(posedge clk) begin
    if (ce) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (ld) begin
      w_state_next = S_SHIFT;
    end else begin
      case (r_state)
        S_SHIFT: w_state_next = S_TRY;
        S_TRY:   if (w_try_last) w_state_next = (r_pair == LAST_PAIR) ? S_DONE : S_SHIFT;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      if (rst) begin
        r_a    <= '0;
        r_q    <= '0;
        r_r    <= '0;
        r_t    <= '0;
        r_d    <= '0;
        r_try  <= '0;
        r_pair <= '0;
        r_o    <= '0;
        r_done <= 1'b0;
      end else if (ld) begin
        r_a    <= a;
        r_q    <= '0;
        r_r    <= '0;
        r_d    <= '0;
        r_try  <= '0;
        r_pair <= '0;
        r_done <= 1'b0;
      end else begin
        case (r_state)
          S_SHIFT: begin
            // Radicand pairs stream out of the top of r_a; zeros follow once a is exhausted.
            r_r   <= {r_r[RW-9:0], w_pair};
            r_a   <= r_a << 8;
            r_t   <= w_t_init;
            r_d   <= '0;
            r_try <= '0;
          end
          S_TRY: begin
            if (w_ge) begin
              r_r <= w_sub;
              r_t <= w_t_inc;
            end
            r_d   <= w_d_next;
            r_try <= r_try + 4'd1;
            if (w_try_last) begin
              r_q <= w_q_next;
              if (r_pair == LAST_PAIR) begin
                r_o    <= w_q_next;
                r_done <= 1'b1;
              end else begin
                r_pair <= r_pair + 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o       = r_o;
  assign done    = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_dfp_bcd_isqrt_iter.sv
// Bench for dfp_bcd_isqrt_iter at N=4: driver pushes floor(sqrt(a*10^12)) and the expected
// completion ce-edge into queues; a monitor pops and compares on each rising done.
module tb_dfp_bcd_isqrt_iter;
  localparam int N  = 4;
  localparam int OW = 8 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          ld;
  logic [4*N-1:0] a;
  logic [OW-1:0] o;
  logic          done;
  logic [1:0]    st;

  always #5 clk = ~clk;

  dfp_bcd_isqrt_iter #(.N(N)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld), .a(a),
    .o(o), .done(done), .o_state(st)
  );

  int total = 0;
  int bad   = 0;
  int ce_cnt = 0;
  logic [OW-1:0] exp_q[$];
  int            exp_edge_q[$];
  logic [OW-1:0] last_o = '0;
  logic          prev_done = 1'b0;

  always @(posedge clk) if (ce) ce_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_bcd(input longint unsigned v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Plain integer floor(sqrt(v * 10^(3N))) by bisection.
  function automatic longint unsigned ref_root(input int unsigned v);
    longint unsigned target, lo, hi, mid, scale, top;
    scale = 1;
    for (int i = 0; i < 3 * N; i++) scale = scale * 10;
    top = 1;
    for (int i = 0; i < 2 * N; i++) top = top * 10;
    target = longint'(v) * scale;
    lo = 0;
    hi = top - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= target) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic int exp_lat(input int unsigned v);
`ifdef BCD_ISQRT_EARLY_EXIT_EN
    return (v == 0) ? 4 * N : -1;
`else
    if (v == 0) return 20 * N;
    return 20 * N;
`endif
  endfunction

  always @(negedge clk) begin
    logic [OW-1:0] e;
    int            ed;
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 o=0x%0h expected no completion at %0t", o, $time);
      end else begin
        e  = exp_q.pop_front();
        ed = exp_edge_q.pop_front();
        check("root", 64'(o), 64'(e));
        if (ed >= 0) check("latency_ce_edges", 64'(ce_cnt), 64'(ed));
        last_o = e;
      end
    end
    prev_done = done;
  end

  task automatic issue(input int unsigned v);
    logic [63:0] b;
    logic [63:0] r;
    int          lat;
    @(negedge clk); #1;
    b = to_bcd(64'(v));
    r = to_bcd(ref_root(v));
    lat = exp_lat(v);
    exp_q.delete();
    exp_edge_q.delete();
    ce = 1'b1;
    ld = 1'b1;
    a  = b[4*N-1:0];
    exp_q.push_back(r[OW-1:0]);
    exp_edge_q.push_back((lat < 0) ? -1 : ce_cnt + 1 + lat);
    @(negedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic wait_done(input int stalls);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
      if (stalls > 0 && $urandom_range(0, 7) == 0) begin
        ce = 1'b0;
        stalls--;
      end else begin
        ce = 1'b1;
      end
    end
    ce = 1'b1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done after %0d cycles expected completion", n);
      exp_q.delete();
      exp_edge_q.delete();
    end
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      ce = 1'b1;
    end
  endtask

  initial begin
    int unsigned dir_v[4];
    dir_v = '{32'd4, 32'd2, 32'd9999, 32'd0};
    rst = 1'b1; ce = 1'b1; ld = 1'b0; a = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check("reset_o", 64'(o), 64'd0);
    check("reset_done", 64'(done), 64'd1 - 64'd1);

    foreach (dir_v[i]) begin
      issue(dir_v[i]);
      wait_done(0);
      advance(3);
      check("done_hold", 64'(done), 64'd1);
      check("o_hold_done", 64'(o), 64'(last_o));
    end

    issue(2);
    wait_done(7);

    // rst is ignored while ce is low
    @(negedge clk); #1;
    ce = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; ce = 1'b1;
    check("rst_gated_done", 64'(done), 64'd1);
    check("rst_gated_o", 64'(o), 64'(last_o));

    // restart mid-operation at ce-edge 30
    issue(9999);
    check("busy_done_low", 64'(done), 64'd0);
    check("busy_o_hold", 64'(o), 64'(last_o));
    advance(28);
    issue(4);
    wait_done(0);

    // rst at ce-edge 40 of an operation
    issue(9999);
    advance(38);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_edge_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    check("abort_done", 64'(done), 64'd0);
    check("abort_o", 64'(o), 64'd0);
    advance(150);
    check("abort_idle_done", 64'(done), 64'd0);
    last_o = '0;

    // rst wins over ld on the same edge
    issue(4);
    wait_done(0);
    @(negedge clk); #1;
    rst = 1'b1; ld = 1'b1; a = 16'h0009;
    exp_q.delete();
    exp_edge_q.delete();
    @(negedge clk); #1;
    rst = 1'b0; ld = 1'b0;
    advance(120);
    check("rst_over_ld_done", 64'(done), 64'd0);
    check("rst_over_ld_o", 64'(o), 64'd0);

    for (int i = 0; i < 20; i++) begin
      issue($urandom_range(0, 9999));
      wait_done($urandom_range(0, 5));
    end

    advance(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
